// File: rtl/conv2d_row_burst.sv
// Stride-1 zero-padded 2D convolution: one OFM row per accumulator pass, one burst read per contributing IFM row, one burst write per row.
// Define CONV2D_RELU_EN to clamp negative results to zero on write-out.
module conv2d_row_burst #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int WT_DIM     = 3,
  parameter int MAX_FM_DIM = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              idle,
  output logic              done,
  input  logic [31:0]       fm_dim,
  input  logic [31:0]       wt_offset,
  input  logic [31:0]       ifm_offset,
  input  logic [31:0]       ofm_offset,
  output logic [AWIDTH-1:0] req_read_addr,
  output logic              req_read_addr_valid,
  input  logic              req_read_addr_ready,
  output logic [31:0]       req_read_len,
  input  logic [DWIDTH-1:0] resp_read_data,
  input  logic              resp_read_data_valid,
  output logic              resp_read_data_ready,
  output logic [AWIDTH-1:0] req_write_addr,
  output logic              req_write_addr_valid,
  input  logic              req_write_addr_ready,
  output logic [31:0]       req_write_len,
  output logic [DWIDTH-1:0] req_write_data,
  output logic              req_write_data_valid,
  input  logic              req_write_data_ready,
  input  logic              resp_write_status,
  input  logic              resp_write_status_valid,
  output logic              resp_write_status_ready
);
  localparam int H   = (WT_DIM - 1) / 2;
  localparam int NW  = WT_DIM * WT_DIM;
  localparam int IW  = (MAX_FM_DIM > 1) ? $clog2(MAX_FM_DIM) : 1;
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WT_REQ, S_WT_DATA, S_ROW_SETUP, S_RD_REQ,
    S_RD_DATA, S_WR_REQ, S_WR_DATA, S_WR_RESP, S_DONE
  } state_t;

  state_t state, nxt;
  logic [31:0] fm_q, wt_q, ifm_q, ofm_q, y, r, col, iy;
  logic [DWIDTH-1:0] w   [NW];
  logic [DWIDTH-1:0] acc [MAX_FM_DIM];
  logic [31:0]       tap_pos [WT_DIM];
  logic              tap_ok  [WT_DIM];
  logic [IW-1:0]     tap_idx [WT_DIM];
  logic [WIW-1:0]    tap_w   [WT_DIM];
  logic [DWIDTH-1:0] wr_word;
  logic rd_hs, wr_hs, st_hs, col_last, wt_last, r_last, row_skip, start_bad;
  logic unused_status;

  assign unused_status = resp_write_status;
  assign rd_hs     = resp_read_data_valid && resp_read_data_ready;
  assign wr_hs     = req_write_data_valid && req_write_data_ready;
  assign st_hs     = resp_write_status_valid && resp_write_status_ready;
  assign col_last  = (col == fm_q - 32'd1);
  assign wt_last   = (col == 32'(NW - 1));
  assign r_last    = (r == 32'(WT_DIM - 1));
  assign iy        = y + r - 32'(H);
  // Halo rows above or below the map contribute nothing and are never fetched.
  assign row_skip  = (y + r < 32'(H)) || (iy >= fm_q);
  assign start_bad = (fm_dim == '0) || (fm_dim > 32'(MAX_FM_DIM));
  assign idle      = (state == S_IDLE) || (state == S_DONE);
  assign done      = (state == S_DONE);
  assign wr_word   = acc[col[IW-1:0]];

`ifdef CONV2D_RELU_EN
  assign req_write_data = wr_word[DWIDTH-1] ? '0 : wr_word;
`else
  assign req_write_data = wr_word;
`endif

  // Beat at column col lands on acc[col-H+k] using weight column WT_DIM-1-k.
  always_comb begin
    for (int k = 0; k < WT_DIM; k++) begin
      tap_pos[k] = col + 32'(k);
      tap_ok[k]  = (tap_pos[k] >= 32'(H)) && (tap_pos[k] - 32'(H) < fm_q);
      tap_idx[k] = IW'(tap_pos[k] - 32'(H));
      tap_w[k]   = WIW'(r * 32'(WT_DIM) + 32'(WT_DIM - 1 - k));
    end
  end

  always_comb begin
    nxt                     = state;
    req_read_addr_valid     = 1'b0;
    req_read_addr           = '0;
    req_read_len            = '0;
    resp_read_data_ready    = 1'b0;
    req_write_addr_valid    = 1'b0;
    req_write_addr          = '0;
    req_write_len           = '0;
    req_write_data_valid    = 1'b0;
    resp_write_status_ready = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) nxt = start_bad ? S_DONE : S_WT_REQ;
      S_WT_REQ: begin
        req_read_addr_valid = 1'b1;
        req_read_addr       = AWIDTH'(wt_q);
        req_read_len        = 32'(NW);
        if (req_read_addr_ready) nxt = S_WT_DATA;
      end
      S_WT_DATA: begin
        resp_read_data_ready = 1'b1;
        if (rd_hs && wt_last) nxt = S_ROW_SETUP;
      end
      S_ROW_SETUP: nxt = S_RD_REQ;
      S_RD_REQ: begin
        if (row_skip) begin
          nxt = r_last ? S_WR_REQ : S_RD_REQ;
        end else begin
          req_read_addr_valid = 1'b1;
          req_read_addr       = AWIDTH'(ifm_q + iy * fm_q);
          req_read_len        = fm_q;
          if (req_read_addr_ready) nxt = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        resp_read_data_ready = 1'b1;
        if (rd_hs && col_last) nxt = r_last ? S_WR_REQ : S_RD_REQ;
      end
      S_WR_REQ: begin
        req_write_addr_valid = 1'b1;
        req_write_addr       = AWIDTH'(ofm_q + y * fm_q);
        req_write_len        = fm_q;
        if (req_write_addr_ready) nxt = S_WR_DATA;
      end
      S_WR_DATA: begin
        req_write_data_valid = 1'b1;
        if (wr_hs && col_last) nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        resp_write_status_ready = 1'b1;
        if (st_hs) nxt = (y == fm_q - 32'd1) ? S_DONE : S_ROW_SETUP;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      y     <= '0;
      r     <= '0;
      col   <= '0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          fm_q  <= fm_dim;
          wt_q  <= wt_offset;
          ifm_q <= ifm_offset;
          ofm_q <= ofm_offset;
          y     <= '0;
        end
        S_WT_REQ:    col <= '0;
        S_WT_DATA:   if (rd_hs) col <= col + 32'd1;
        S_ROW_SETUP: r <= '0;
        S_RD_REQ: begin
          col <= '0;
          if (row_skip) r <= r + 32'd1;
        end
        S_RD_DATA: if (rd_hs) begin
          col <= col + 32'd1;
          if (col_last) r <= r + 32'd1;
        end
        S_WR_REQ:  col <= '0;
        S_WR_DATA: if (wr_hs) col <= col + 32'd1;
        S_WR_RESP: if (st_hs) y <= y + 32'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WT_DATA && rd_hs) w[col[WIW-1:0]] <= resp_read_data;
    if (state == S_ROW_SETUP) begin
      for (int i = 0; i < MAX_FM_DIM; i++) acc[i] <= '0;
    end else if (state == S_RD_DATA && rd_hs) begin
      for (int k = 0; k < WT_DIM; k++)
        if (tap_ok[k]) acc[tap_idx[k]] <= acc[tap_idx[k]] + resp_read_data * w[tap_w[k]];
    end
  end
endmodule

// File: tb/tb_conv2d_row_burst.sv
// Bench for conv2d_row_burst: bus responder with optional stalls, scoreboard of expected requests and write beats.
module tb_conv2d_row_burst;
  localparam int WT_OFF = 0, IFM_OFF = 100, OFM_OFF = 200, BOUND = 5000;

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] len; } req_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } beat_t;

  logic clk = 0, rst = 1, start = 0;
  logic [31:0] fm_dim = 0, wt_offset = WT_OFF, ifm_offset = IFM_OFF, ofm_offset = OFM_OFF;
  logic idle, done;
  logic [31:0] req_read_addr, req_read_len, req_write_addr, req_write_len, req_write_data;
  logic req_read_addr_valid, resp_read_data_ready, req_write_addr_valid, req_write_data_valid, resp_write_status_ready;
  logic req_read_addr_ready = 0, resp_read_data_valid = 0, req_write_addr_ready = 0;
  logic req_write_data_ready = 0, resp_write_status = 0, resp_write_status_valid = 0;
  logic [31:0] resp_read_data = 0;

  conv2d_row_burst dut (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .done(done), .fm_dim(fm_dim),
    .wt_offset(wt_offset), .ifm_offset(ifm_offset), .ofm_offset(ofm_offset),
    .req_read_addr(req_read_addr), .req_read_addr_valid(req_read_addr_valid),
    .req_read_addr_ready(req_read_addr_ready), .req_read_len(req_read_len),
    .resp_read_data(resp_read_data), .resp_read_data_valid(resp_read_data_valid),
    .resp_read_data_ready(resp_read_data_ready), .req_write_addr(req_write_addr),
    .req_write_addr_valid(req_write_addr_valid), .req_write_addr_ready(req_write_addr_ready),
    .req_write_len(req_write_len), .req_write_data(req_write_data),
    .req_write_data_valid(req_write_data_valid), .req_write_data_ready(req_write_data_ready),
    .resp_write_status(resp_write_status), .resp_write_status_valid(resp_write_status_valid),
    .resp_write_status_ready(resp_write_status_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [31:0] mem [0:1023];
  req_t exp_req [$];
  beat_t exp_beat [$];
  bit stall_en = 0, saw_valid = 0, stat_pend = 0, prev_rstall = 0, prev_wstall = 0;
  int n_rd = 0, n_wr = 0, rd_left = 0, wr_left = 0;
  logic [31:0] rd_ptr, wr_ptr, prev_raddr, prev_rlen, prev_waddr, prev_wlen;
  req_t mon_e;
  beat_t mon_b;
  logic [31:0] exp_ones [9] = '{4, 6, 4, 6, 9, 6, 4, 6, 4};

  function automatic bit go();
    return (!stall_en) || ($urandom_range(99, 0) >= 30);
  endfunction

  // Memory-side responder: samples DUT outputs and drives responses on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_left = 0; wr_left = 0; stat_pend = 0; prev_rstall = 0; prev_wstall = 0;
        req_read_addr_ready = 0; resp_read_data_valid = 0; req_write_addr_ready = 0;
        req_write_data_ready = 0; resp_write_status_valid = 0;
      end else begin
        if (req_read_addr_valid || req_write_addr_valid || req_write_data_valid) saw_valid = 1;
        if (prev_rstall) begin
          vectors++;
          if (!req_read_addr_valid || req_read_addr !== prev_raddr || req_read_len !== prev_rlen) begin
            miscompares++;
            $display("FAIL rd_req_stable: got addr %h len %0d vld %b, held %h len %0d", req_read_addr, req_read_len, req_read_addr_valid, prev_raddr, prev_rlen);
          end
        end
        if (prev_wstall) begin
          vectors++;
          if (!req_write_addr_valid || req_write_addr !== prev_waddr || req_write_len !== prev_wlen) begin
            miscompares++;
            $display("FAIL wr_req_stable: got addr %h len %0d vld %b, held %h len %0d", req_write_addr, req_write_len, req_write_addr_valid, prev_waddr, prev_wlen);
          end
        end
        resp_read_data_valid = 0;
        if (rd_left > 0) begin
          resp_read_data_valid = go();
          resp_read_data = mem[rd_ptr[9:0]];
          if (resp_read_data_ready) begin rd_ptr++; rd_left--; end
          if (!resp_read_data_valid && resp_read_data_ready) begin rd_ptr--; rd_left++; end
        end
        resp_write_status_valid = 0;
        if (stat_pend) begin
          resp_write_status_valid = go();
          if (resp_write_status_valid && resp_write_status_ready) stat_pend = 0;
        end
        req_write_data_ready = 0;
        if (wr_left > 0) begin
          req_write_data_ready = go();
          if (req_write_data_valid && req_write_data_ready) begin
            mem[wr_ptr[9:0]] = req_write_data;
            vectors++;
            if (exp_beat.size() == 0) begin
              miscompares++;
              $display("FAIL wr_beat: got unexpected beat %h at %h, required none", req_write_data, wr_ptr);
            end else begin
              mon_b = exp_beat.pop_front();
              if (mon_b.addr !== wr_ptr || mon_b.data !== req_write_data) begin
                miscompares++;
                $display("FAIL wr_beat: got %h at %h, required %h at %h", req_write_data, wr_ptr, mon_b.data, mon_b.addr);
              end
            end
            wr_ptr++; wr_left--;
            if (wr_left == 0) stat_pend = 1;
          end
        end
        req_read_addr_ready = go();
        prev_rstall = req_read_addr_valid && !req_read_addr_ready;
        prev_raddr = req_read_addr; prev_rlen = req_read_len;
        if (req_read_addr_valid && req_read_addr_ready) begin
          n_rd++; vectors++;
          if (exp_req.size() == 0) begin
            miscompares++;
            $display("FAIL rd_req: got %h len %0d, required no request", req_read_addr, req_read_len);
          end else begin
            mon_e = exp_req.pop_front();
            if (mon_e.wr || mon_e.addr !== req_read_addr || mon_e.len !== req_read_len) begin
              miscompares++;
              $display("FAIL rd_req: got read %h len %0d, required wr=%0b %h len %0d", req_read_addr, req_read_len, mon_e.wr, mon_e.addr, mon_e.len);
            end
          end
          rd_ptr = req_read_addr; rd_left = int'(req_read_len);
        end
        req_write_addr_ready = go();
        prev_wstall = req_write_addr_valid && !req_write_addr_ready;
        prev_waddr = req_write_addr; prev_wlen = req_write_len;
        if (req_write_addr_valid && req_write_addr_ready) begin
          n_wr++; vectors++;
          if (exp_req.size() == 0) begin
            miscompares++;
            $display("FAIL wr_req: got %h len %0d, required no request", req_write_addr, req_write_len);
          end else begin
            mon_e = exp_req.pop_front();
            if (!mon_e.wr || mon_e.addr !== req_write_addr || mon_e.len !== req_write_len) begin
              miscompares++;
              $display("FAIL wr_req: got write %h len %0d, required wr=%0b %h len %0d", req_write_addr, req_write_len, mon_e.wr, mon_e.addr, mon_e.len);
            end
          end
          wr_ptr = req_write_addr; wr_left = int'(req_write_len);
        end
      end
    end
  end

  // Reference model: direct windowed convolution over bench memory, 3x3 kernel, zero halo.
  task automatic expect_job(input int fm);
    req_t q;
    beat_t b;
    logic [31:0] sum;
    int iy, ix;
    q.wr = 0; q.addr = 32'(WT_OFF); q.len = 32'd9; exp_req.push_back(q);
    for (int y = 0; y < fm; y++) begin
      for (int r = 0; r < 3; r++) begin
        iy = y + r - 1;
        if (iy >= 0 && iy < fm) begin
          q.wr = 0; q.addr = 32'(IFM_OFF + iy * fm); q.len = 32'(fm); exp_req.push_back(q);
        end
      end
      q.wr = 1; q.addr = 32'(OFM_OFF + y * fm); q.len = 32'(fm); exp_req.push_back(q);
      for (int x = 0; x < fm; x++) begin
        sum = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            iy = y + r - 1; ix = x + c - 1;
            if (iy >= 0 && iy < fm && ix >= 0 && ix < fm)
              sum = sum + mem[10'(IFM_OFF + iy * fm + ix)] * mem[10'(WT_OFF + r * 3 + c)];
          end
`ifdef CONV2D_RELU_EN
        if (sum[31]) sum = 0;
`endif
        b.addr = 32'(OFM_OFF + y * fm + x); b.data = sum; exp_beat.push_back(b);
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2; rst = 1; start = 0;
    @(posedge clk); #2; rst = 0;
    exp_req.delete(); exp_beat.delete();
  endtask

  task automatic run_job(input int fm, input bit poke_busy);
    int cyc;
    expect_job(fm);
    @(posedge clk); #2; fm_dim = 32'(fm); start = 1;
    @(posedge clk); #2; start = 0;
    vectors++;
    if (done !== 1'b0 || idle !== 1'b0) begin
      miscompares++;
      $display("FAIL job_started: got done=%b idle=%b, required done=0 idle=0", done, idle);
    end
    if (poke_busy) begin
      repeat (20) @(posedge clk);
      #2; fm_dim = 32'd5; start = 1;
      @(posedge clk); #2; start = 0; fm_dim = 32'(fm);
    end
    cyc = 0;
    while (!done && cyc < BOUND) begin @(posedge clk); #2; cyc++; end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL job_done: got done=%b after %0d cycles, required 1", done, cyc);
    end
    vectors++;
    if (exp_req.size() != 0 || exp_beat.size() != 0) begin
      miscompares++;
      $display("FAIL job_drained: got %0d reqs %0d beats left, required 0 0", exp_req.size(), exp_beat.size());
    end
  endtask

  task automatic load_ones(input logic [31:0] wv);
    for (int i = 0; i < 9; i++) begin
      mem[10'(WT_OFF + i)] = wv; mem[10'(IFM_OFF + i)] = 32'd1; mem[10'(OFM_OFF + i)] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic check_ones(input string tag);
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (mem[10'(OFM_OFF + i)] !== exp_ones[i]) begin
        miscompares++;
        $display("FAIL %s ofm[%0d]: got %0d, required %0d", tag, i, mem[10'(OFM_OFF + i)], exp_ones[i]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (idle !== 1'b1 || done !== 1'b0 || req_read_addr_valid !== 1'b0 || req_write_addr_valid !== 1'b0 ||
        req_write_data_valid !== 1'b0 || resp_read_data_ready !== 1'b0 || resp_write_status_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got idle=%b done=%b rv=%b wv=%b dv=%b rr=%b sr=%b, required 1 0 0 0 0 0 0", idle, done,
               req_read_addr_valid, req_write_addr_valid, req_write_data_valid, resp_read_data_ready, resp_write_status_ready);
    end
    rst = 0;
  endtask

  task automatic test_single();
    for (int i = 0; i < 9; i++) mem[10'(WT_OFF + i)] = 32'(i + 1);
    mem[IFM_OFF] = 32'd7; mem[OFM_OFF] = 32'd0;
    n_rd = 0; n_wr = 0;
    run_job(1, 0);
    vectors++;
    if (mem[OFM_OFF] !== 32'd35 || n_rd != 2 || n_wr != 1) begin
      miscompares++;
      $display("FAIL single: got ofm=%0d rd=%0d wr=%0d, required 35 2 1", mem[OFM_OFF], n_rd, n_wr);
    end
  endtask

  task automatic test_all_ones(input bit stalls, input string tag);
    stall_en = stalls;
    load_ones(32'd1);
    n_rd = 0; n_wr = 0;
    run_job(3, stalls);
    check_ones(tag);
    vectors++;
    if (n_rd != 8 || n_wr != 3) begin
      miscompares++;
      $display("FAIL %s bursts: got rd=%0d wr=%0d, required 8 3", tag, n_rd, n_wr);
    end
    stall_en = 0;
  endtask

  task automatic test_negative();
    logic [31:0] want_c, want_k;
`ifdef CONV2D_RELU_EN
    want_c = 32'd0; want_k = 32'd0;
`else
    want_c = 32'hFFFF_FFF7; want_k = 32'hFFFF_FFFC;
`endif
    load_ones(32'hFFFF_FFFF);
    run_job(3, 0);
    vectors++;
    if (mem[OFM_OFF + 4] !== want_c || mem[OFM_OFF] !== want_k) begin
      miscompares++;
      $display("FAIL negative: got center=%h corner=%h, required %h %h", mem[OFM_OFF + 4], mem[OFM_OFF], want_c, want_k);
    end
  endtask

  task automatic test_degenerate();
    logic [31:0] bad [2];
    int cyc;
    bad = '{32'd0, 32'd65};
    for (int j = 0; j < 2; j++) begin
      apply_reset();
      saw_valid = 0;
      #0; fm_dim = bad[j]; start = 1;
      @(posedge clk); #2; start = 0;
      cyc = 1;
      while (!done && cyc < 2) begin @(posedge clk); #2; cyc++; end
      vectors++;
      if (done !== 1'b1 || idle !== 1'b1) begin
        miscompares++;
        $display("FAIL degenerate_done fm=%0d: got done=%b idle=%b, required 1 1", bad[j], done, idle);
      end
      repeat (10) @(posedge clk);
      #2;
      vectors++;
      if (saw_valid) begin
        miscompares++;
        $display("FAIL degenerate_traffic fm=%0d: got a valid request, required none", bad[j]);
      end
    end
  endtask

  task automatic test_reset_midjob();
    int cyc;
    apply_reset();
    load_ones(32'd1);
    n_rd = 0; n_wr = 0;
    expect_job(3);
    fm_dim = 32'd3; start = 1;
    @(posedge clk); #2; start = 0;
    cyc = 0;
    while (!(n_wr == 1 && rd_left > 0) && cyc < BOUND) begin @(posedge clk); #2; cyc++; end
    vectors++;
    if (!(n_wr == 1 && rd_left > 0)) begin
      miscompares++;
      $display("FAIL midjob_reach: got wr=%0d rd_left=%0d, required 1 >0", n_wr, rd_left);
    end
    rst = 1;
    @(posedge clk); #2;
    vectors++;
    if (idle !== 1'b1 || done !== 1'b0 || req_read_addr_valid !== 1'b0 || req_write_addr_valid !== 1'b0 ||
        req_write_data_valid !== 1'b0 || resp_read_data_ready !== 1'b0 || resp_write_status_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midjob_reset: got idle=%b done=%b rv=%b wv=%b dv=%b rr=%b, required 1 0 0 0 0 0", idle, done,
               req_read_addr_valid, req_write_addr_valid, req_write_data_valid, resp_read_data_ready);
    end
    rst = 0;
    exp_req.delete(); exp_beat.delete();
    for (int i = 0; i < 9; i++) mem[10'(OFM_OFF + i)] = 32'hDEAD_BEEF;
    run_job(3, 0);
    check_ones("restart");
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ones(0, "ones");
    test_all_ones(1, "stall");
    test_negative();
    test_degenerate();
    test_reset_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/conv2d_row_burst.md
Name: conv2d_row_burst

Overview:
- Next-generation 2D convolution engine: stride 1, zero padding (halo), weights loaded once into registers.
- Each OFM row is built in an on-chip row accumulator fed by one burst read per contributing IFM row. Each finished row leaves as one burst write.
- Each incoming IFM word drives WT_DIM parallel MACs, so each IFM row is fetched at most WT_DIM times in total, not once per window.
- Sits behind the IO-DMem memory controller, using the same read/write request/response channel set as the naive conv2D engine.

Parameters:
- AWIDTH, 32, address width (word addresses).
- DWIDTH, 32, data width; signed two's complement elements.
- WT_DIM, 3, kernel dimension; odd, >=1; H = (WT_DIM-1)/2.
- MAX_FM_DIM, 64, accumulator depth; largest legal fm_dim.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin job; ignored unless idle.
- idle  out  1  high in IDLE/DONE.
- done  out  1  high from job completion until next start or rst.
- fm_dim  in  32  IFM/OFM side length; sampled on accepted start.
- wt_offset, ifm_offset, ofm_offset  in  32 each  word base addresses; sampled on start.
- req_read_addr  out  AWIDTH  read burst address.
- req_read_addr_valid  out  1  read request valid.
- req_read_addr_ready  in  1  read request ready.
- req_read_len  out  32  read burst length in beats.
- resp_read_data  in  DWIDTH  read data beat.
- resp_read_data_valid  in  1  read data valid.
- resp_read_data_ready  out  1  read data ready.
- req_write_addr  out  AWIDTH  write burst address.
- req_write_addr_valid  out  1  write request valid.
- req_write_addr_ready  in  1  write request ready.
- req_write_len  out  32  write burst length in beats.
- req_write_data  out  DWIDTH  write data beat.
- req_write_data_valid  out  1  write data valid.
- req_write_data_ready  in  1  write data ready.
- resp_write_status  in  1  write status (value ignored).
- resp_write_status_valid  in  1  write status valid.
- resp_write_status_ready  out  1  write status ready.

Behaviour:
- Reset:
  - All valid/ready outputs 0; done=0; idle=1; state IDLE.
  - A reset mid-job abandons any outstanding transaction; outputs are low on the cycle after rst.
- Handshakes:
  - A transfer occurs when valid and ready are both high on the same edge.
  - A request's valid, addr and len are held stable until accepted.
- States and transitions:
  - IDLE --start--> WT_REQ.
  - fm_dim==0 or fm_dim>MAX_FM_DIM: start goes directly to DONE with no traffic.
  - WT_REQ: addr=wt_offset, len=WT_DIM*WT_DIM. On accept -> WT_DATA.
  - WT_DATA: resp_read_data_ready=1. Beats fill w[r][c] row-major. After the last beat -> row setup with y=0.
  - Row setup: clear acc[0..fm_dim-1]; r=0.
  - RD_REQ: IFM row iy=y+r-H.
    - If iy<0 or iy>=fm_dim, skip (no request) and advance r.
    - Otherwise addr=ifm_offset+iy*fm_dim, len=fm_dim.
  - RD_DATA: beat at column c adds ifm*w[r][c-x+H] to acc[x] for x in c-H..c+H, all WT_DIM in one cycle. Indices outside [0,fm_dim) are discarded.
  - After r==WT_DIM-1 -> WR_REQ: addr=ofm_offset+y*fm_dim, len=fm_dim.
  - WR_DATA: stream acc[0..fm_dim-1] in order, one per accepted beat.
  - WR_RESP: resp_write_status_ready=1; wait for one status handshake.
  - Then y++; if y==fm_dim -> DONE, else row setup.
  - DONE: done=1, idle=1; start -> WT_REQ and clears done the same cycle.
- Timing:
  - done rises the cycle after the final status handshake.
  - A new read request is issued the cycle after the last beat of the previous burst.
- Arithmetic: products and sums are truncated to DWIDTH (wrap modulo 2^DWIDTH).
- Concurrency: at most one read burst and one write burst outstanding; reads and writes never overlap.
- Extra or early data beats outside the DATA states are not accepted (ready=0).

Optional Feature:
- CONV2D_RELU_EN
  - Defined: each write beat outputs max(acc,0) by signed compare.
  - Undefined: raw acc is written.
  - Accumulation and traffic are identical either way.

Test Plan:
- 1. Single element: fm_dim=1, w=1..9, ifm=[7].
  - ofm=[35].
  - Traffic: exactly one weight read len 9, one IFM read len 1 at ifm_offset, one write len 1.
- 2. All ones: fm_dim=3, all w=1, all ifm=1.
  - ofm=[4,6,4;6,9,6;4,6,4].
  - Exactly 7 IFM read bursts of len 3 and 3 write bursts of len 3.
- 3. Backpressure: test 2 with random ready/valid stalls on every channel (30% idle).
  - Identical ofm and transaction order.
  - Request fields never change while valid && !ready.
- 4. Negative result: all w=-1, ifm=1, fm_dim=3.
  - Without macro: center=32'hFFFFFFF7.
  - With CONV2D_RELU_EN: all zeros.
- 5. Degenerate fm_dim: fm_dim=0 and fm_dim=MAX_FM_DIM+1.
  - done within 2 cycles, no valid ever asserted.
  - start while busy: no effect on results.
- 6. Reset mid-job: rst during RD_DATA of row 1.
  - Next cycle all valids low, idle=1, done=0.
  - Restart with test 2 yields correct ofm.
